// File: rtl/fetch_ctl_pkg.sv
// Shared select encodings and state type for the fetch-stage sequencer.
package fetch_ctl_pkg;

    localparam logic [1:0] PC_Z4   = 2'd0;
    localparam logic [1:0] PC_INC  = 2'd1;
    localparam logic [1:0] PC_HOLD = 2'd2;
    localparam logic [1:0] PC_BR   = 2'd3;

    localparam logic [1:0] IR_MEM  = 2'd0;
    localparam logic [1:0] IR_NOP  = 2'd1;
    localparam logic [1:0] IR_HOLD = 2'd2;

    localparam logic PC2_INC  = 1'b0;
    localparam logic PC2_HOLD = 1'b1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (en && (count != 16'hFFFF))
            count <= count + 16'd1;
    end

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage sequencer: PC/IR2/PC2 mux selects, redirect bubbles, stall
// counters and a stall watchdog.
//   state | meaning
//   BOOT  | first cycle after reset, IR2 fed a NOP, PC held
//   RUN   | normal fetch, redirects and load-use stalls handled here
//   FLUSH | post-redirect NOP bubbles, bcnt counts remaining bubbles
module fetch_control
    import fetch_ctl_pkg::*;
#(
    parameter int BR_BUBBLES = 1,
    parameter int JR_BUBBLES = 2,
    parameter int MAX_STALL  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_req,
    input  logic        branch_taken,
    input  logic        jr_taken,
    output logic [1:0]  select_pc,
    output logic [1:0]  select_ir2,
    output logic        select_pc2,
    output logic        flush_active,
    output logic [15:0] stall_count,
    output logic [15:0] redirect_count,
    output logic        stall_timeout
);

    localparam logic [2:0]  BR_LOAD    = 3'(BR_BUBBLES - 1);
    localparam logic [2:0]  JR_LOAD    = 3'(JR_BUBBLES - 1);
    localparam logic [15:0] STALL_LAST = 16'(MAX_STALL - 1);

    fetch_state_t state_q, state_d;
    logic [2:0]   bcnt_q, bcnt_d;
    logic [15:0]  run_cnt_q;
    logic         stall_inc, redir_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        select_pc    = PC_INC;
        select_ir2   = IR_MEM;
        select_pc2   = PC2_INC;
        flush_active = 1'b0;
        stall_inc    = 1'b0;
        redir_inc    = 1'b0;
        case (state_q)
            BOOT: begin
                select_pc    = PC_HOLD;
                select_ir2   = IR_NOP;
                flush_active = 1'b1;
                state_d      = RUN;
            end
            RUN: begin
                if (jr_taken) begin
                    select_pc    = PC_Z4;
                    select_ir2   = IR_NOP;
                    flush_active = 1'b1;
                    redir_inc    = 1'b1;
                    bcnt_d       = JR_LOAD;
                    state_d      = (JR_BUBBLES > 1) ? FLUSH : RUN;
                end else if (branch_taken) begin
                    select_pc    = PC_BR;
                    select_ir2   = IR_NOP;
                    flush_active = 1'b1;
                    redir_inc    = 1'b1;
                    bcnt_d       = BR_LOAD;
                    state_d      = (BR_BUBBLES > 1) ? FLUSH : RUN;
                end else if (stall_req) begin
                    select_pc  = PC_HOLD;
                    select_ir2 = IR_HOLD;
                    select_pc2 = PC2_HOLD;
                    stall_inc  = 1'b1;
                end
            end
            FLUSH: begin
                select_ir2   = IR_NOP;
                flush_active = 1'b1;
                // Branch/stall here come from squashed wrong-path instructions.
                if (jr_taken) begin
                    select_pc = PC_Z4;
                    redir_inc = 1'b1;
                    bcnt_d    = JR_LOAD;
                    state_d   = (JR_BUBBLES > 1) ? FLUSH : RUN;
                end else begin
                    bcnt_d = bcnt_q - 3'd1;
                    if (bcnt_q <= 3'd1)
                        state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Watchdog only counts RUN cycles that are genuinely stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt_q     <= '0;
            stall_timeout <= 1'b0;
        end else if (stall_inc) begin
            if (run_cnt_q != 16'hFFFF)
                run_cnt_q <= run_cnt_q + 16'd1;
            if (run_cnt_q == STALL_LAST)
                stall_timeout <= 1'b1;
        end else begin
            run_cnt_q <= '0;
        end
    end

    sat_counter u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_inc),
        .count (stall_count)
    );

    sat_counter u_redir_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (redir_inc),
        .count (redirect_count)
    );

endmodule

// File: doc/fetch_control.md
# fetch_control

Sequencing controller for the fetch stage of the five-stage pipeline. Each cycle it drives the PC mux, the IR2 mux and the PC2 mux select lines from hazard and redirect requests raised by stages 2–4. It inserts NOP bubbles after redirects and holds fetch during load-use stalls. It also keeps saturating stall and redirect event counters and a stall watchdog.

## Interface
Parameters:
- BR_BUBBLES, 1: NOP cycles injected into IR2 for a stage-3 branch redirect, counting the redirect cycle itself; legal range 1–7.
- JR_BUBBLES, 2: NOP cycles injected for a stage-4 register-jump redirect, counting the redirect cycle; legal range 1–7.
- MAX_STALL, 64: consecutive `stall_req` cycles that set `stall_timeout`; legal range 2–65535.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall_req  in  1  load-use hazard from stage 2.
- branch_taken  in  1  stage 3 resolved taken branch; target on branchaddress.
- jr_taken  in  1  stage 4 register jump; target forwarded on z4.
- select_pc  out  2  0 = z4, 1 = incremented PC, 2 = hold PC, 3 = branchaddress.
- select_ir2  out  2  0 = instruction memory, 1 = NOP, 2 = hold IR2.
- select_pc2  out  1  0 = incremented PC, 1 = hold PC2.
- flush_active  out  1  high in every NOP-injecting cycle.
- stall_count  out  16  saturating count of stall cycles.
- redirect_count  out  16  saturating count of accepted redirects.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- The FSM has three states: BOOT, RUN and FLUSH. It also has a 3-bit bubble counter `bcnt`.
- Select outputs are Mealy: they are combinational from state and current-cycle inputs.
- BOOT:
  - Entered on reset.
  - Outputs are select_pc = 2, select_ir2 = 1, select_pc2 = 0, flush_active = 1.
  - Goes to RUN after exactly one clock edge. All inputs are ignored.
- RUN priority is jr_taken > branch_taken > stall_req > normal.
  - Normal: select_pc = 1, select_ir2 = 0, select_pc2 = 0.
  - jr_taken:
    - Outputs: select_pc = 0, select_ir2 = 1, select_pc2 = 0, flush_active = 1.
    - redirect_count increments.
    - If JR_BUBBLES > 1, go to FLUSH with bcnt = JR_BUBBLES − 1. Otherwise stay in RUN.
  - branch_taken: same as jr_taken, except select_pc = 3 and the bubble count comes from BR_BUBBLES.
  - stall_req:
    - Outputs: select_pc = 2, select_ir2 = 2, select_pc2 = 1.
    - stall_count increments. State stays RUN.
- FLUSH:
  - Outputs: select_pc = 1, select_ir2 = 1, select_pc2 = 0, flush_active = 1.
  - bcnt decrements each cycle. Go to RUN when bcnt reaches 0; the cycle with bcnt = 1 is the last FLUSH cycle.
  - branch_taken and stall_req are ignored, because they come from squashed wrong-path instructions.
  - jr_taken is honoured. It drives the jr_taken outputs above, reloads bcnt = JR_BUBBLES − 1 and increments redirect_count. If JR_BUBBLES = 1, go to RUN.
- Watchdog:
  - The run counter increments on each RUN cycle with stall_req high and no higher-priority event.
  - It clears on any other cycle.
  - stall_timeout sets when the run counter reaches MAX_STALL. It clears only on reset.
- Both 16-bit counters saturate at 0xFFFF and never wrap.

## Timing
- Reset values:
  - State BOOT, bcnt = 0.
  - select_pc = 2, select_ir2 = 1, select_pc2 = 0, flush_active = 1.
  - stall_count = 0, redirect_count = 0, stall_timeout = 0.
- Reset asserted mid-FLUSH or mid-stall forces the reset values immediately (asynchronous); no redirect is pending afterwards.
- Select latency is zero cycles: an event at cycle n changes the selects in cycle n.
- Counters and stall_timeout update on the clock edge that ends the event cycle.
- A stall of length k holds the PC for k cycles. Normal fetch resumes in the cycle stall_req drops.
- jr_taken and branch_taken together: jr wins, only one redirect is counted, and branchaddress is unused.

## Structure
- Package `fetch_ctl_pkg` holds:
  - select encodings: PC_Z4, PC_INC, PC_HOLD, PC_BR; IR_MEM, IR_NOP, IR_HOLD; PC2_INC, PC2_HOLD.
  - state enum: BOOT, RUN, FLUSH.
- Sub-module `sat_counter` is a 16-bit saturating incrementer with enable and async reset. It is instantiated twice, for stall_count and redirect_count.
- The FSM, bcnt and watchdog live in the top level.

## Test plan
- Reset release, no requests: cycle 0 BOOT gives selects 2/1/0. Cycle 1 onward gives 1/0/0 with flush_active = 0.
- branch_taken for one cycle in RUN (defaults): that cycle gives select_pc = 3 and select_ir2 = 1. The next cycle is back to 1/0/0. redirect_count = 1.
- jr_taken for one cycle (JR_BUBBLES = 2): cycle n gives select_pc = 0 with NOP. Cycle n+1 is FLUSH (1/1/0). Cycle n+2 is RUN. branch_taken pulsed at n+1 is ignored and redirect_count = 1.
- stall_req held 3 cycles: selects 2/2/1 for those 3 cycles, then stall_count = 3. With MAX_STALL = 3, stall_timeout = 1 after the third edge and stays high.
- jr_taken and branch_taken in the same cycle: select_pc = 0 and redirect_count increments by 1. Reset asserted in the following FLUSH cycle gives all reset values immediately.
- Force stall_count to 0xFFFE, then apply 3 stall cycles: stall_count holds at 0xFFFF.
